// File: rtl/dds_pkg.sv
// -----------------------------------------------------------------------------
// dds_pkg
// Shared types and constants for the DDS tone sequencer.
//   PHASE_W         : phase accumulator / increment width (sine LUT address width)
//   DUR_W           : tone duration counter width, in clk cycles
//   dds_seq_state_t : sequencer FSM state
//   dds_tone_t      : one tone table entry (phase increment, duration)
//   dur_eff()       : maps a programmed duration onto the cycles actually played
// -----------------------------------------------------------------------------
package dds_pkg;

    localparam int PHASE_W = 8;
    localparam int DUR_W   = 16;

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } dds_seq_state_t;

    typedef struct packed {
        logic [PHASE_W-1:0] inc;
        logic [DUR_W-1:0]   dur;
    } dds_tone_t;

    // A programmed duration of 0 still plays for one cycle.
    function automatic logic [DUR_W-1:0] dur_eff(input logic [DUR_W-1:0] d);
        return (d == '0) ? DUR_W'(1) : d;
    endfunction

endpackage

// File: rtl/dds_tone_sequencer_if.sv
// -----------------------------------------------------------------------------
// dds_tone_sequencer_if
// Host-side bus of the DDS tone sequencer.
//   Config  : cfg_we, cfg_addr, cfg_inc, cfg_dur   (table write, IDLE only)
//   Control : num_tones, start, stop
//   Status  : busy, done, out_valid, tone_idx
//   DDS     : phase_inc, phase_acc                  (phase_acc addresses the sine LUT)
// Modports: master = host / bench, slave = sequencer.
// -----------------------------------------------------------------------------
interface dds_tone_sequencer_if
    import dds_pkg::*;
#(
    parameter int DEPTH = 8
);
    localparam int AW = $clog2(DEPTH);

    logic               cfg_we;
    logic [AW-1:0]      cfg_addr;
    logic [PHASE_W-1:0] cfg_inc;
    logic [DUR_W-1:0]   cfg_dur;
    logic [AW:0]        num_tones;
    logic               start;
    logic               stop;
    logic               busy;
    logic               done;
    logic               out_valid;
    logic [AW-1:0]      tone_idx;
    logic [PHASE_W-1:0] phase_inc;
    logic [PHASE_W-1:0] phase_acc;

    modport master (
        output cfg_we, cfg_addr, cfg_inc, cfg_dur, num_tones, start, stop,
        input  busy, done, out_valid, tone_idx, phase_inc, phase_acc
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_inc, cfg_dur, num_tones, start, stop,
        output busy, done, out_valid, tone_idx, phase_inc, phase_acc
    );

endinterface

// File: rtl/dds_phase_acc.sv
// -----------------------------------------------------------------------------
// dds_phase_acc
// PHASE_W-wide phase accumulator with clear / load / add controls.
// Priority: rst, i_clear, i_load, i_add. Addition wraps modulo 2^PHASE_W.
//   clk        in  : clock
//   rst        in  : synchronous active-high reset
//   i_clear    in  : force accumulator to 0
//   i_load     in  : load i_load_val
//   i_load_val in  : value for load
//   i_add      in  : accumulate i_inc
//   i_inc      in  : phase increment
//   o_acc      out : accumulator value
// -----------------------------------------------------------------------------
module dds_phase_acc
    import dds_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_clear,
    input  logic               i_load,
    input  logic [PHASE_W-1:0] i_load_val,
    input  logic               i_add,
    input  logic [PHASE_W-1:0] i_inc,
    output logic [PHASE_W-1:0] o_acc
);

    logic [PHASE_W-1:0] r_acc;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_acc <= '0;
        end else if (i_load) begin
            r_acc <= i_load_val;
        end else if (i_add) begin
            r_acc <= r_acc + i_inc;
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/dds_tone_sequencer.sv
// -----------------------------------------------------------------------------
// dds_tone_sequencer
// Plays a programmed list of (phase increment, duration) tones by driving a
// DDS phase accumulator cycle by cycle; phase_acc addresses an external sine LUT.
//   clk  in      : clock, all logic on posedge
//   rst  in      : synchronous active-high reset (tone table is not reset)
//   bus  slave   : dds_tone_sequencer_if (config, start/stop, status, phase outputs)
// Build option:
//   DDS_SEQ_LOOP_EN : when defined, the tone list repeats from tone 0 with
//                     continuous phase, pulsing done on each wrap; only stop
//                     or rst return to IDLE. Undefined: single-shot playback.
// -----------------------------------------------------------------------------
module dds_tone_sequencer
    import dds_pkg::*;
#(
    parameter int DEPTH = 8
)(
    input  logic               clk,
    input  logic               rst,
    dds_tone_sequencer_if.slave bus
);

    localparam int AW = $clog2(DEPTH);

    // Tone table. Small enough for distributed RAM; the asynchronous read lets
    // the next tone be loaded on the same edge that ends the current one.
    dds_tone_t          r_table [DEPTH];

    dds_seq_state_t     r_state;
    logic               r_busy;
    logic               r_done;
    logic               r_valid;
    logic [AW-1:0]      r_tone_idx;
    logic [PHASE_W-1:0] r_phase_inc;
    logic [DUR_W-1:0]   r_dur_cnt;
    logic [AW:0]        r_num_tones;

    logic               w_play;
    logic               w_start_ok;
    logic               w_last;
    logic               w_tone_end;
    logic               w_seq_end;
    logic [AW-1:0]      w_next_idx;
    dds_tone_t          w_first_tone;
    dds_tone_t          w_next_tone;
    logic               w_acc_clear;
    logic [PHASE_W-1:0] w_phase_acc;

    assign w_play       = (r_state == PLAY);
    assign w_start_ok   = bus.start && !bus.stop && (bus.num_tones != '0)
                          && (bus.num_tones <= (AW+1)'(DEPTH));
    assign w_last       = ({1'b0, r_tone_idx} == (r_num_tones - (AW+1)'(1)));
    assign w_tone_end   = w_play && !bus.stop && (r_dur_cnt == DUR_W'(1));
    assign w_next_idx   = r_tone_idx + AW'(1);
    assign w_first_tone = r_table[0];
    assign w_next_tone  = r_table[w_next_idx];

`ifdef DDS_SEQ_LOOP_EN
    assign w_seq_end = 1'b0;
`else
    assign w_seq_end = w_tone_end && w_last;
`endif

    // Table is frozen while a sequence plays.
    always_ff @(posedge clk) begin
        if (bus.cfg_we && !w_play) begin
            r_table[bus.cfg_addr] <= '{inc: bus.cfg_inc, dur: bus.cfg_dur};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_valid     <= 1'b0;
            r_tone_idx  <= '0;
            r_phase_inc <= '0;
            r_dur_cnt   <= '0;
            r_num_tones <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start_ok) begin
                        r_state     <= PLAY;
                        r_busy      <= 1'b1;
                        r_valid     <= 1'b1;
                        r_tone_idx  <= '0;
                        r_phase_inc <= w_first_tone.inc;
                        r_dur_cnt   <= dur_eff(w_first_tone.dur);
                        r_num_tones <= bus.num_tones;
                    end
                end
                PLAY: begin
                    if (bus.stop) begin
                        // Abort: same outputs as a normal end, without done.
                        r_state     <= IDLE;
                        r_busy      <= 1'b0;
                        r_valid     <= 1'b0;
                        r_tone_idx  <= '0;
                        r_phase_inc <= '0;
                    end else if (w_tone_end) begin
                        if (w_last) begin
                            r_done <= 1'b1;
`ifdef DDS_SEQ_LOOP_EN
                            r_tone_idx  <= '0;
                            r_phase_inc <= w_first_tone.inc;
                            r_dur_cnt   <= dur_eff(w_first_tone.dur);
`else
                            r_state     <= IDLE;
                            r_busy      <= 1'b0;
                            r_valid     <= 1'b0;
                            r_tone_idx  <= '0;
                            r_phase_inc <= '0;
`endif
                        end else begin
                            r_tone_idx  <= w_next_idx;
                            r_phase_inc <= w_next_tone.inc;
                            r_dur_cnt   <= dur_eff(w_next_tone.dur);
                        end
                    end else begin
                        r_dur_cnt <= r_dur_cnt - DUR_W'(1);
                    end
                end
            endcase
        end
    end

    // The accumulator keeps adding the outgoing tone's increment on a tone
    // change, so phase stays continuous; it is held at 0 outside PLAY.
    assign w_acc_clear = !w_play || bus.stop || w_seq_end;

    dds_phase_acc u_phase_acc (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_acc_clear),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_add      (w_play),
        .i_inc      (r_phase_inc),
        .o_acc      (w_phase_acc)
    );

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.out_valid = r_valid;
    assign bus.tone_idx  = r_tone_idx;
    assign bus.phase_inc = r_phase_inc;
    assign bus.phase_acc = w_phase_acc;

endmodule

// File: tb/tb_dds_tone_sequencer.sv
// -----------------------------------------------------------------------------
// tb_dds_tone_sequencer
// Directed bench for dds_tone_sequencer with hand-computed expected values.
// Inputs change 1 ns after the rising edge; outputs are sampled at that point.
// -----------------------------------------------------------------------------
module tb_dds_tone_sequencer;
    import dds_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    dds_tone_sequencer_if #(.DEPTH(8)) bus ();

    dds_tone_sequencer #(.DEPTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One line and one set of comparisons per observed cycle.
    task automatic check_cycle(input string tag, input logic b, input logic v, input logic d,
                               input logic [2:0] idx, input logic [7:0] inc, input logic [7:0] acc);
        $display("%s: busy=%0d valid=%0d done=%0d idx=%0d inc=%0d acc=%0d",
                 tag, bus.busy, bus.out_valid, bus.done, bus.tone_idx, bus.phase_inc, bus.phase_acc);
        check({tag, ".busy"},  32'(bus.busy),      32'(b));
        check({tag, ".valid"}, 32'(bus.out_valid), 32'(v));
        check({tag, ".done"},  32'(bus.done),      32'(d));
        check({tag, ".idx"},   32'(bus.tone_idx),  32'(idx));
        check({tag, ".inc"},   32'(bus.phase_inc), 32'(inc));
        check({tag, ".acc"},   32'(bus.phase_acc), 32'(acc));
    endtask

    task automatic load(input logic [2:0] a, input logic [7:0] inc, input logic [15:0] dur);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = a;
        bus.cfg_inc  = inc;
        bus.cfg_dur  = dur;
        tick();
        bus.cfg_we   = 1'b0;
    endtask

    // Returns in the first PLAY cycle when the start is accepted.
    task automatic start_seq(input logic [3:0] n);
        bus.start     = 1'b1;
        bus.num_tones = n;
        tick();
        bus.start     = 1'b0;
    endtask

    logic [7:0] e_acc [10];
    logic [7:0] e_inc [10];
    logic [2:0] e_idx [10];
    logic       e_done [10];

    initial begin
        bus.cfg_we    = 1'b0;
        bus.cfg_addr  = '0;
        bus.cfg_inc   = '0;
        bus.cfg_dur   = '0;
        bus.num_tones = '0;
        bus.start     = 1'b0;
        bus.stop      = 1'b0;
        rst           = 1'b1;
        tick(); tick(); tick();
        rst = 1'b0;

        check_cycle("reset", 0, 0, 0, 0, 0, 0);

        // num_tones outside 1..DEPTH is rejected.
        load(0, 8'd1, 16'd2);
        load(1, 8'd10, 16'd3);
        start_seq(4'd0);
        check_cycle("num0", 0, 0, 0, 0, 0, 0);
        start_seq(4'd9);
        check_cycle("num9", 0, 0, 0, 0, 0, 0);

        // start and stop together: stop wins.
        bus.start = 1'b1; bus.stop = 1'b1; bus.num_tones = 4'd1;
        tick();
        bus.start = 1'b0; bus.stop = 1'b0;
        check_cycle("startstop", 0, 0, 0, 0, 0, 0);

        // stop on the 2nd PLAY cycle: idle next cycle, no done.
        start_seq(4'd2);
        check_cycle("stop.c0", 1, 1, 0, 0, 1, 0);
        tick();
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        check_cycle("stop.end", 0, 0, 0, 0, 0, 0);
        tick();
        check_cycle("stop.after", 0, 0, 0, 0, 0, 0);

        // rst mid-play clears outputs, no done pulse.
        start_seq(4'd2);
        tick(); tick();
        check_cycle("rstmid.c2", 1, 1, 0, 1, 10, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_cycle("rstmid.end", 0, 0, 0, 0, 0, 0);
        tick();
        check_cycle("rstmid.after", 0, 0, 0, 0, 0, 0);

`ifdef DDS_SEQ_LOOP_EN
        // Two tones of dur 2 repeating, done on each wrap.
        load(0, 8'd3, 16'd2);
        load(1, 8'd5, 16'd2);
        e_idx  = '{0, 0, 1, 1, 0, 0, 1, 1, 0, 0};
        e_inc  = '{3, 3, 5, 5, 3, 3, 5, 5, 3, 3};
        e_acc  = '{0, 3, 6, 11, 16, 19, 22, 27, 32, 35};
        e_done = '{0, 0, 0, 0, 1, 0, 0, 0, 1, 0};
        start_seq(4'd2);
        for (int i = 0; i < 10; i++) begin
            check_cycle($sformatf("loop.c%0d", i), 1, 1, e_done[i], e_idx[i], e_inc[i], e_acc[i]);
            tick();
        end
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        check_cycle("loop.stop", 0, 0, 0, 0, 0, 0);
`else
        // Single tone inc=5 dur=4.
        load(0, 8'd5, 16'd4);
        start_seq(4'd1);
        for (int i = 0; i < 4; i++) begin
            check_cycle($sformatf("t1.c%0d", i), 1, 1, 0, 0, 5, 8'(5 * i));
            tick();
        end
        check_cycle("t1.end", 0, 0, 1, 0, 0, 0);
        tick();
        check_cycle("t1.after", 0, 0, 0, 0, 0, 0);

        // Two tones; cfg_we and start during play are ignored.
        load(0, 8'd1, 16'd2);
        load(1, 8'd10, 16'd3);
        e_idx = '{0, 0, 1, 1, 1, 0, 0, 0, 0, 0};
        e_inc = '{1, 1, 10, 10, 10, 0, 0, 0, 0, 0};
        e_acc = '{0, 1, 2, 12, 22, 0, 0, 0, 0, 0};
        for (int r = 0; r < 2; r++) begin
            start_seq(4'd2);
            for (int i = 0; i < 5; i++) begin
                check_cycle($sformatf("t2.r%0d.c%0d", r, i), 1, 1, 0, e_idx[i], e_inc[i], e_acc[i]);
                if (r == 0 && i == 0) begin
                    bus.cfg_we = 1'b1; bus.cfg_addr = 3'd0;
                    bus.cfg_inc = 8'd99; bus.cfg_dur = 16'd7;
                    bus.start = 1'b1; bus.num_tones = 4'd1;
                end
                tick();
                bus.cfg_we = 1'b0;
                bus.start  = 1'b0;
            end
            check_cycle($sformatf("t2.r%0d.end", r), 0, 0, 1, 0, 0, 0);
            tick();
        end

        // Phase wraps modulo 256.
        load(0, 8'd200, 16'd3);
        start_seq(4'd1);
        e_acc = '{0, 200, 144, 0, 0, 0, 0, 0, 0, 0};
        for (int i = 0; i < 3; i++) begin
            check_cycle($sformatf("t3.c%0d", i), 1, 1, 0, 0, 200, e_acc[i]);
            tick();
        end
        check_cycle("t3.end", 0, 0, 1, 0, 0, 0);
        tick();

        // dur=0 plays exactly one cycle.
        load(0, 8'd7, 16'd0);
        start_seq(4'd1);
        check_cycle("dur0.c0", 1, 1, 0, 0, 7, 0);
        tick();
        check_cycle("dur0.end", 0, 0, 1, 0, 0, 0);
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
